// File: rtl/col2im_2d_stream.sv
// col2im_2d_stream
//
// Streaming inverse of the im2col lowering. Column-matrix elements arrive one
// per handshake in [i][p] order (kernel row i outer, window position p inner,
// with p = j*HP + k and k fastest). Each element is added into the image pixel
// it was originally gathered from, so overlapping windows sum. After the last
// element of a frame is accepted, the reconstructed image is streamed out in
// row-major order. Each drained pixel is cleared as it leaves, so the buffer is
// clean for the next frame.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   in_valid    column element valid
//   in_ready    block can accept an element (high while accumulating)
//   in_data     column-matrix element, unsigned DATA_WIDTH
//   out_valid   image pixel valid (high while draining)
//   out_ready   downstream accepts the pixel
//   out_data    accumulated image pixel, ACC_WIDTH
//   frame_done  one-cycle pulse on the last output pixel handshake

module col2im_2d_stream #(
  parameter int IMAGE_WIDTH          = 20,
  parameter int IMAGE_HEIGHT         = 20,
  parameter int KERNEL_SIZE          = 3,
  parameter int STRIDE               = 1,
  parameter int DATA_WIDTH           = 8,
  parameter int HORIZONTAL_POSITIONS = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1,
  parameter int VERTICAL_POSITIONS   = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
  parameter int ACC_WIDTH            = DATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  frame_done
);

  localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int KW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int HPW    = (HORIZONTAL_POSITIONS > 1) ? $clog2(HORIZONTAL_POSITIONS) : 1;
  localparam int VPW    = (VERTICAL_POSITIONS > 1) ? $clog2(VERTICAL_POSITIONS) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_next;

  // Input position counters. The kernel row index i is kept split into its
  // column offset (ox = i % K) and row offset (oy = i / K) so no divider is
  // needed to locate the target pixel.
  logic [KW-1:0]  off_x;
  logic [KW-1:0]  off_y;
  logic [VPW-1:0] win_j;
  logic [HPW-1:0] win_k;

  // Output pixel index while draining.
  logic [ADDR_W-1:0] pix;

  logic [ACC_WIDTH-1:0] pix_buf [PIXELS];

  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              out_fire;
  logic              k_last;
  logic              j_last;
  logic              x_last;
  logic              y_last;
  logic              beat_last;
  logic              pix_last;

  // ---------------------------------------------------------------------------
  // Handshakes and counter terminal conditions
  // ---------------------------------------------------------------------------
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign k_last    = (win_k == HPW'(HORIZONTAL_POSITIONS - 1));
  assign j_last    = (win_j == VPW'(VERTICAL_POSITIONS - 1));
  assign x_last    = (off_x == KW'(KERNEL_SIZE - 1));
  assign y_last    = (off_y == KW'(KERNEL_SIZE - 1));
  assign beat_last = k_last && j_last && x_last && y_last;
  assign pix_last  = (pix == ADDR_W'(PIXELS - 1));

  // Target pixel of the current element: (j*S + oy, k*S + ox). Padding is
  // zero, so this is always inside the image.
  always_comb begin
    int y_pos;
    int x_pos;
    y_pos = int'(win_j) * STRIDE + int'(off_y);
    x_pos = int'(win_k) * STRIDE + int'(off_x);
    addr  = ADDR_W'(y_pos * IMAGE_WIDTH + x_pos);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each combinational process
  // guarantees a value on every path, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (accept && beat_last)  state_next = DRAIN;
      DRAIN: if (out_fire && pix_last) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // out_data is read straight from the buffer at pix. The buffer entry and pix
  // only change on an output handshake, so the pixel holds while stalled.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    frame_done = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
      end
      DRAIN: begin
        out_valid  = 1'b1;
        out_data   = pix_buf[pix];
        frame_done = out_ready && pix_last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input position counters: k -> j -> (ox -> oy)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_k <= '0;
      win_j <= '0;
      off_x <= '0;
      off_y <= '0;
    end else if (accept) begin
      if (beat_last) begin
        win_k <= '0;
        win_j <= '0;
        off_x <= '0;
        off_y <= '0;
      end else if (!k_last) begin
        win_k <= win_k + HPW'(1);
      end else begin
        win_k <= '0;
        if (!j_last) begin
          win_j <= win_j + VPW'(1);
        end else begin
          win_j <= '0;
          if (!x_last) begin
            off_x <= off_x + KW'(1);
          end else begin
            off_x <= '0;
            off_y <= off_y + KW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output pixel counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pix <= '0;
    end else if (out_fire) begin
      pix <= pix_last ? '0 : pix + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Image buffer
  // ---------------------------------------------------------------------------
  // Read-modify-write happens in one cycle against the register array itself,
  // so back-to-back elements to the same pixel always see the updated sum and
  // no forwarding path is needed. Accumulate and clear never overlap: the first
  // happens only in ACCUM, the second only in DRAIN.
  // NOTE: this buffer is built from flops rather than a RAM macro because reset
  // must clear every entry in a single cycle to discard an aborted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < PIXELS; n++) begin
        pix_buf[n] <= '0;
      end
    end else if (accept) begin
      pix_buf[addr] <= pix_buf[addr] + ACC_WIDTH'(in_data);
    end else if (out_fire) begin
      pix_buf[pix] <= '0;
    end
  end

endmodule

// File: tb/tb_col2im_2d_stream.sv
// tb_col2im_2d_stream
//
// Directed bench for col2im_2d_stream. Two instances are built:
//   dut_a: W=H=4, K=3, S=1 (HP=VP=2)
//   dut_b: W=H=5, K=3, S=2 (HP=VP=2)
// A select signal routes the shared stimulus to one instance at a time.
// Expected images are hand-written tables, scaled versions of them, or a
// plain loop-nest col2im model for the random-data frame.

module tb_col2im_2d_stream;

  localparam int DW = 8;
  localparam int AW = 12;

  localparam int PAT4 [16] = '{1, 2, 2, 1,
                               2, 4, 4, 2,
                               2, 4, 4, 2,
                               1, 2, 2, 1};

  localparam int PAT5 [25] = '{1, 1, 2, 1, 1,
                               1, 1, 2, 1, 1,
                               2, 2, 4, 2, 2,
                               1, 1, 2, 1, 1,
                               1, 1, 2, 1, 1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          frame_done;

  logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a, frame_done_a;
  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, frame_done_b;
  logic [AW-1:0] out_data_a, out_data_b;

  int checks = 0;
  int errors = 0;
  int stim    [64];
  int exp_img [64];

  always #5 clk = ~clk;

  assign in_valid_a  = !sel && in_valid;
  assign out_ready_a = !sel && out_ready;
  assign in_valid_b  = sel && in_valid;
  assign out_ready_b = sel && out_ready;

  assign in_ready   = sel ? in_ready_b   : in_ready_a;
  assign out_valid  = sel ? out_valid_b  : out_valid_a;
  assign out_data   = sel ? out_data_b   : out_data_a;
  assign frame_done = sel ? frame_done_b : frame_done_a;

  col2im_2d_stream #(
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(4),
    .KERNEL_SIZE (3),
    .STRIDE      (1),
    .DATA_WIDTH  (DW)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a),
    .frame_done(frame_done_a)
  );

  col2im_2d_stream #(
    .IMAGE_WIDTH (5),
    .IMAGE_HEIGHT(5),
    .KERNEL_SIZE (3),
    .STRIDE      (2),
    .DATA_WIDTH  (DW)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .frame_done(frame_done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_stim(input int n, input int value);
    for (int b = 0; b < n; b++) stim[b] = value;
  endtask

  task automatic set_exp4(input int scale);
    for (int p = 0; p < 16; p++) exp_img[p] = PAT4[p] * scale;
  endtask

  // Reference col2im: walk the [i][j][k] input order and add into (y, x).
  task automatic model_img(input int w, input int h, input int k, input int s);
    int hp, vp, b;
    hp = (w - k) / s + 1;
    vp = (h - k) / s + 1;
    b  = 0;
    for (int p = 0; p < w * h; p++) exp_img[p] = 0;
    for (int i = 0; i < k * k; i++)
      for (int j = 0; j < vp; j++)
        for (int kk = 0; kk < hp; kk++) begin
          exp_img[(j * s + i / k) * w + (kk * s + i % k)] += stim[b];
          b++;
        end
  endtask

  // Offer stim[0..n-1]; each cycle in_valid is dropped with probability gap_pct.
  // Returns at #1 after the edge that took the n-th element.
  task automatic send_beats(input string tag, input int n, input int gap_pct);
    int b   = 0;
    int cyc = 0;
    while (b < n && cyc < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = DW'(stim[b]);
      if (in_valid && in_ready) b++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " beats"}, b, n);
  endtask

  // Take `take` pixels of a `total`-pixel frame with out_ready dropped at
  // bp_pct. Every cycle, including stall cycles, the presented pixel must
  // equal the next expected one.
  task automatic recv_pixels(input string tag, input int take, input int total, input int bp_pct);
    int p   = 0;
    int cyc = 0;
    while (p < take && cyc < 4000) begin
      out_ready = ($urandom_range(99) >= bp_pct);
      #1;
      check({tag, " valid"}, out_valid, 1);
      check({tag, " in_ready"}, in_ready, 0);
      check({tag, " data"}, out_data, exp_img[p]);
      check({tag, " frame_done"}, frame_done, (out_ready && p == total - 1));
      if (out_ready && out_valid) p++;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, " pixels"}, p, take);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst frame_done", frame_done, 0);

    // All-ones frame, no gaps: first out_valid right after the 36th accept.
    fill_stim(36, 1);
    set_exp4(1);
    send_beats("ones", 36, 0);
    check("ones first valid", out_valid, 1);
    check("ones drain in_ready", in_ready, 0);
    recv_pixels("ones", 16, 16, 0);
    check("ones back to accum", in_ready, 1);
    check("ones valid low", out_valid, 0);

    // Full-scale inputs: corners 255, centre 1020.
    fill_stim(36, 255);
    set_exp4(255);
    send_beats("max", 36, 0);
    recv_pixels("max", 16, 16, 0);

    // Stride 2 on the 5x5 instance.
    sel = 1'b1;
    fill_stim(36, 1);
    for (int p = 0; p < 25; p++) exp_img[p] = PAT5[p];
    send_beats("s2", 36, 0);
    check("s2 first valid", out_valid, 1);
    recv_pixels("s2", 25, 25, 0);
    check("s2 back to accum", in_ready, 1);
    sel = 1'b0;
    @(posedge clk);
    #1;

    // Beat-index data with random input gaps and output backpressure.
    for (int b = 0; b < 36; b++) stim[b] = b % 256;
    model_img(4, 4, 3, 1);
    send_beats("rand", 36, 40);
    recv_pixels("rand", 16, 16, 50);

    // Back-to-back frames: the second must be exactly twice the first.
    fill_stim(36, 1);
    set_exp4(1);
    send_beats("b2b1", 36, 0);
    recv_pixels("b2b1", 16, 16, 0);
    fill_stim(36, 2);
    set_exp4(2);
    send_beats("b2b2", 36, 0);
    recv_pixels("b2b2", 16, 16, 30);

    // Abort mid-accumulation after 20 beats, then a clean all-ones frame.
    fill_stim(36, 1);
    send_beats("abort part", 20, 0);
    pulse_rst();
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    set_exp4(1);
    send_beats("abort full", 36, 0);
    recv_pixels("abort full", 16, 16, 0);

    // Abort mid-drain after 3 pixels, then a clean all-ones frame.
    fill_stim(36, 3);
    set_exp4(3);
    send_beats("dabort", 36, 0);
    recv_pixels("dabort part", 3, 16, 0);
    pulse_rst();
    check("dabort out_valid", out_valid, 0);
    check("dabort out_data", out_data, 0);
    check("dabort in_ready", in_ready, 1);
    fill_stim(36, 1);
    set_exp4(1);
    send_beats("dabort full", 36, 0);
    recv_pixels("dabort full", 16, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
